// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR output conditioning path.
package fir_pkg;

    localparam int DataWidth = 12;
    // Widest product of a sample shifted left by up to 7 bits.
    localparam int WideWidth = DataWidth + 7;
    // Attenuation runs 0..DataWidth inclusive.
    localparam int AttWidth  = $clog2(DataWidth + 1);

    typedef logic signed [DataWidth-1:0] sample_t;
    typedef logic signed [WideWidth-1:0] wide_t;

    typedef enum logic [1:0] {
        ACTIVE    = 2'd0,
        RAMP_DOWN = 2'd1,
        MUTED     = 2'd2,
        RAMP_UP   = 2'd3
    } mute_state_e;

    localparam sample_t SampleMax = sample_t'({1'b0, {(DataWidth-1){1'b1}}});
    localparam sample_t SampleMin = sample_t'({1'b1, {(DataWidth-1){1'b0}}});

    // A wide value fits in a sample when every bit from the sample sign bit up agrees.
    function automatic logic fits(input wide_t wide);
        logic [WideWidth-DataWidth:0] top_bits;
        top_bits = wide[WideWidth-1:DataWidth-1];
        return (top_bits == '0) || (top_bits == '1);
    endfunction

    // Clamp a wide value to the signed sample range.
    function automatic sample_t saturate(input wide_t wide);
        if (fits(wide)) begin
            return sample_t'(wide[DataWidth-1:0]);
        end else if (wide[WideWidth-1]) begin
            return SampleMin;
        end else begin
            return SampleMax;
        end
    endfunction

endpackage

// File: rtl/fir_output_conditioner_fifo.sv
// Small elastic FIFO between the conditioning pipeline and the I2S consumer.
// The head is presented combinationally; while empty the last popped word is held.
module sample_fifo #(
    parameter int DataWidth = 12,
    parameter int FifoDepth = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] din,
    output logic [DataWidth-1:0] dout,
    output logic                 empty,
    output logic                 overflow
);

    localparam int AddrWidth = $clog2(FifoDepth);
    localparam logic [AddrWidth:0] CountFull = (AddrWidth + 1)'(FifoDepth);

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [AddrWidth-1:0] wr_ptr_reg;
    logic [AddrWidth-1:0] rd_ptr_reg;
    logic [AddrWidth:0]   count_reg;
    logic [DataWidth-1:0] last_reg;
    logic                 overflow_reg;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CountFull);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers, occupancy, held output word and sticky overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            last_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                last_reg   <= mem[rd_ptr_reg];
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign dout     = empty ? last_reg : mem[rd_ptr_reg];
    assign overflow = overflow_reg;

endmodule

// File: rtl/fir_output_conditioner.sv
// Gain with saturation, click-free mute ramp and elastic output FIFO
// between the FIR filter and the I2S DAC input. Sample width comes from fir_pkg.
module fir_output_conditioner
    import fir_pkg::*;
#(
    parameter int FifoDepth      = 4,
    parameter int ClipCountWidth = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DataWidth-1:0]      inData,
    input  logic                      inValid,
    input  logic [2:0]                gainShift,
    input  logic                      muteReq,
    output logic [DataWidth-1:0]      outData,
    output logic                      outValid,
    input  logic                      outReady,
    output logic                      muted,
    output logic                      overflow,
    output logic [ClipCountWidth-1:0] clipCount
);

    localparam logic [AttWidth-1:0] AttFull = AttWidth'(DataWidth);

    wide_t                     wide_ext;
    wide_t                     wide;
    sample_t                   sat;
    logic                      clip;
    logic                      s1_valid_reg;
    sample_t                   s1_data_reg;
    logic [AttWidth-1:0]       s1_att_reg;
    sample_t                   scaled;
    mute_state_e               state_reg;
    mute_state_e               state_next;
    logic [AttWidth-1:0]       att_reg;
    logic [AttWidth-1:0]       att_next;
    logic [AttWidth-1:0]       att_up;
    logic [AttWidth-1:0]       att_down;
    logic [ClipCountWidth-1:0] clip_count_reg;
    logic                      fifo_empty;
    logic                      pop;

    // Stage 1 gain: sign-extend, shift, clamp.
    assign wide_ext = {{(WideWidth - DataWidth){inData[DataWidth-1]}}, inData};
    assign wide     = wide_ext <<< gainShift;
    assign sat      = saturate(wide);
    assign clip     = !fits(wide);

    // Stage 1 register: clamped sample plus the attenuation in force when it was accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_att_reg   <= '0;
        end else begin
            s1_valid_reg <= inValid;
            if (inValid) begin
                s1_data_reg <= sat;
                s1_att_reg  <= att_reg;
            end
        end
    end

    // Stage 2 attenuation: full mute forces exact zero rather than -1.
    always_comb begin
        scaled = '0;
        if (s1_att_reg < AttFull) begin
            scaled = s1_data_reg >>> s1_att_reg;
        end
    end

    // Mute FSM state register; only advances on accepted samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ACTIVE;
            att_reg   <= '0;
        end else begin
            state_reg <= state_next;
            att_reg   <= att_next;
        end
    end

    assign att_up   = att_reg + 1'b1;
    assign att_down = att_reg - 1'b1;

    // Mute FSM next state: step attenuation one notch per sample toward the request.
    always_comb begin
        state_next = state_reg;
        att_next   = att_reg;
        if (inValid) begin
            case (state_reg)
                ACTIVE: begin
                    if (muteReq) begin
                        att_next   = att_up;
                        state_next = (att_up == AttFull) ? MUTED : RAMP_DOWN;
                    end
                end
                RAMP_DOWN, RAMP_UP: begin
                    if (muteReq) begin
                        att_next   = att_up;
                        state_next = (att_up == AttFull) ? MUTED : RAMP_DOWN;
                    end else begin
                        att_next   = att_down;
                        state_next = (att_down == '0) ? ACTIVE : RAMP_UP;
                    end
                end
                MUTED: begin
                    if (!muteReq) begin
                        att_next   = att_down;
                        state_next = (att_down == '0) ? ACTIVE : RAMP_UP;
                    end
                end
                default: begin
                    state_next = ACTIVE;
                    att_next   = '0;
                end
            endcase
        end
    end

    // Mute FSM outputs.
    always_comb begin
        muted = (state_reg == MUTED);
    end

    // Saturating count of clamped input samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            clip_count_reg <= '0;
        end else if (inValid && clip && (clip_count_reg != '1)) begin
            clip_count_reg <= clip_count_reg + 1'b1;
        end
    end

    assign clipCount = clip_count_reg;
    assign pop       = outValid && outReady;
    assign outValid  = !fifo_empty;

    sample_fifo #(
        .DataWidth (DataWidth),
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk      (clk),
        .srst     (reset),
        .push     (s1_valid_reg),
        .pop      (pop),
        .din      (scaled),
        .dout     (outData),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

endmodule

// File: doc/fir_output_conditioner.md
Name: fir_output_conditioner

Overview:
Downstream stage between the FIR filter output (y, done) and the I2S controller DAC input. It applies a programmable power-of-two gain with saturation, a click-free mute ramp and a small elastic FIFO, so that FIR bursts and I2S sample requests are decoupled. It reports clipping and overflow for debug readout.

Parameters:
DataWidth, 12, signed sample width in and out
FifoDepth, 4, output FIFO entries (power of two, >=2)
ClipCountWidth, 8, width of saturating clip counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
inData  input  DataWidth  signed FIR output sample
inValid  input  1  one-cycle strobe, inData valid (FIR done)
gainShift  input  3  left-shift gain 0..7, sampled with each accepted sample
muteReq  input  1  level; 1 = ramp to silence, 0 = ramp back to unity
outData  output  DataWidth  signed sample at FIFO head
outValid  output  1  FIFO non-empty
outReady  input  1  consumer pop; pop occurs when outValid && outReady
muted  output  1  high only in MUTED state
overflow  output  1  sticky; a sample was dropped on full FIFO
clipCount  output  ClipCountWidth  saturating count of clipped samples

Behaviour:
- One clock (clk), synchronous active-high reset. Reset: FIFO empty, outValid=0, outData=0, muted=0, overflow=0, clipCount=0, att=0, state=ACTIVE.
- Stage 1 (cycle N, inValid=1): wide = inData <<< gainShift at DataWidth+7 bits; sat = clamp to [-2^(DataWidth-1), 2^(DataWidth-1)-1]. Clamping is a clip event: clipCount += 1, holding at all-ones.
- Stage 2 (N+1): scaled = sat >>> att (arithmetic). When att >= DataWidth, scaled = 0 (forces 0, not -1). Result is pushed into the FIFO at the end of N+1.
- Latency: with an empty FIFO, outValid=1 with the sample at the head in cycle N+2.
- Mute FSM, advanced only on accepted samples (stage-1 strobe):
  - ACTIVE (att=0): muteReq=1 -> RAMP_DOWN.
  - RAMP_DOWN: att++ per sample. att reaching DataWidth -> MUTED. muteReq=0 -> RAMP_UP.
  - MUTED: att=DataWidth, muted=1. muteReq=0 -> RAMP_UP.
  - RAMP_UP: att-- per sample. att reaching 0 -> ACTIVE. muteReq=1 -> RAMP_DOWN.
  - The sample that triggers a transition uses the att value before the update.
- FIFO: push when stage-2 output is valid and (not full, or a pop occurs in the same cycle). Pop when outValid && outReady.
  - Push on full without a pop: the sample is dropped, overflow is set and held until reset, and the pointers are unchanged.
  - Simultaneous push+pop on empty is impossible, because outValid=0 when empty.
  - Simultaneous push+pop on non-empty: the count is unchanged and ordering is preserved.
- Pointers wrap modulo FifoDepth. Count is kept at log2(FifoDepth)+1 bits.
- outData holds its value while outValid=0 (last popped or reset value).
- A gainShift change takes effect on the next accepted sample. There is no glitch on in-flight samples.
- inValid asserted on consecutive cycles is legal. Each cycle is processed (full pipeline throughput 1/cycle).
- reset mid-operation: all state, including in-flight pipeline samples and FIFO contents, is discarded in the reset cycle.

Decomposition:
- Shared package fir_pkg: DataWidth constant, sample_t (signed logic [DataWidth-1:0]), mute_state_e enum {ACTIVE, RAMP_DOWN, MUTED, RAMP_UP}, saturate function.
- One sub-module: sample_fifo (parameterised DataWidth/FifoDepth; push, pop, full, empty, overflow).
- Gain, mute FSM and clip counter stay in the top.

Test Plan:
- Reset, then inData=100, gainShift=2, inValid pulse at cycle 5 -> outValid=1 at cycle 7, outData=400, clipCount=0.
- inData=1000, gainShift=2 -> outData=2047, clipCount=1. inData=-1000, gainShift=3 -> outData=-2048, clipCount=2. After 300 clipping samples, clipCount=255.
- muteReq=1, feed 14 samples of 2047 -> outputs 2047,1023,511,...,1,0,0; muted=1 from the 13th sample onward. muteReq=0 -> att ramps 12..0 back to 2047 and muted=0.
- outReady=0, push 5 samples 1..5 -> FIFO holds 1..4, overflow=1. Release outReady -> pops 1,2,3,4, then outValid=0.
- FIFO full, outReady=1, push 9 in the same cycle -> accepted, overflow unchanged (0 if set fresh), later order ...,9.
- Reset asserted with 3 samples in FIFO and 1 in the pipeline -> the next cycle has outValid=0, overflow=0, clipCount=0, and no stale sample emerges.
